// File: rtl/guess_pkg.sv
// Shared constants for the guessing-game datapath: default parameters,
// Fibonacci LFSR tap masks and the enter-debounce tracker states.
package guess_pkg;

  localparam int unsigned DEF_VAL_W       = 4;
  localparam int unsigned DEF_REM_W       = 4;
  localparam int unsigned DEF_MAX_GUESSES = 4;
  localparam int unsigned DEF_DB_CYCLES   = 16;

  typedef enum logic {
    IDLE_MATCH = 1'b0,
    COUNTING   = 1'b1
  } db_state_e;

  // Maximal-length feedback taps (bit i set = stage i+1 feeds the XOR).
  function automatic logic [7:0] lfsr_taps(input int unsigned w);
    case (w)
      4:       lfsr_taps = 8'b0000_1100;
      5:       lfsr_taps = 8'b0001_0100;
      6:       lfsr_taps = 8'b0011_0000;
      7:       lfsr_taps = 8'b0110_0000;
      8:       lfsr_taps = 8'b1011_1000;
      default: lfsr_taps = 8'b0000_1100;
    endcase
  endfunction

endpackage

// File: rtl/guess_datapath_enter_debounce.sv
// Enter-key synchronizer and debouncer: the level changes only after the
// synchronized input disagrees with it for DB_CYCLES consecutive clocks.
module enter_debounce
  import guess_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level
);

  localparam int unsigned CW = $clog2(DB_CYCLES);

  logic          sync1;
  logic          s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          level_n;
  db_state_e     state;

  // The tracker state is not stored; it is whether s and the level disagree.
  always_comb begin
    state   = (s == o_level) ? IDLE_MATCH : COUNTING;
    cnt_n   = '0;
    level_n = o_level;
    if (state == COUNTING) begin
      if (cnt == CW'(DB_CYCLES - 1)) begin
        level_n = s;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      s       <= 1'b0;
      cnt     <= '0;
      o_level <= 1'b0;
    end else begin
      sync1   <= i_raw;
      s       <= sync1;
      cnt     <= cnt_n;
      o_level <= level_n;
    end
  end

endmodule

// File: rtl/guess_datapath.sv
// Guessing-game datapath: secret value, synchronized guess, compare flags,
// result LEDs and remaining-guess counter. Define GUESS_LFSR_EN for an LFSR secret.
module guess_datapath
  import guess_pkg::*;
#(
  parameter int unsigned VAL_W       = DEF_VAL_W,
  parameter int unsigned REM_W       = DEF_REM_W,
  parameter int unsigned MAX_GUESSES = DEF_MAX_GUESSES,
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enter_raw,
  input  logic [VAL_W-1:0] i_guess,
  input  logic             i_inc_actual,
  input  logic             i_update_leds,
  input  logic             i_remain_en,
  output logic             o_enter,
  output logic             o_over,
  output logic             o_under,
  output logic             o_equal,
  output logic [REM_W-1:0] o_remain,
  output logic             o_led_over,
  output logic             o_led_under,
  output logic             o_led_equal
);

  logic [VAL_W-1:0] guess_s1;
  logic [VAL_W-1:0] guess_q;
  logic [VAL_W-1:0] actual;
  logic [VAL_W-1:0] actual_next;

`ifdef GUESS_LFSR_EN
  localparam logic [VAL_W-1:0] TAPS      = VAL_W'(lfsr_taps(VAL_W));
  localparam logic [VAL_W-1:0] ACT_RESET = VAL_W'(1);
  assign actual_next = {actual[VAL_W-2:0], ^(actual & TAPS)};
`else
  localparam logic [VAL_W-1:0] ACT_RESET = '0;
  assign actual_next = actual + VAL_W'(1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      guess_s1 <= '0;
      guess_q  <= '0;
      actual   <= ACT_RESET;
    end else begin
      guess_s1 <= i_guess;
      guess_q  <= guess_s1;
      if (i_inc_actual) actual <= actual_next;
    end
  end

  assign o_over  = guess_q > actual;
  assign o_under = guess_q < actual;
  assign o_equal = guess_q == actual;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_led_over  <= 1'b0;
      o_led_under <= 1'b0;
      o_led_equal <= 1'b0;
    end else if (i_update_leds) begin
      o_led_over  <= o_over;
      o_led_under <= o_under;
      o_led_equal <= o_equal;
    end
  end

  // A new round (reload) takes priority over consuming a guess.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_remain <= REM_W'(MAX_GUESSES);
    end else if (i_inc_actual) begin
      o_remain <= REM_W'(MAX_GUESSES);
    end else if (i_remain_en && (o_remain != '0)) begin
      o_remain <= o_remain - REM_W'(1);
    end
  end

  enter_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_enter_debounce (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (i_enter_raw),
    .o_level(o_enter)
  );

endmodule

// File: tb/tb_guess_datapath.sv
// Scoreboard bench for guess_datapath: stimulus queues expected output
// snapshots, a negedge monitor pops and compares them.
module tb_guess_datapath;

  localparam int unsigned VAL_W = 4;
  localparam int unsigned REM_W = 4;

  localparam logic [10:0] M_REM = 11'h00F;
  localparam logic [10:0] M_LED = 11'h070;
  localparam logic [10:0] M_FLG = 11'h380;
  localparam logic [10:0] M_ENT = 11'h400;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             i_enter_raw = 1'b0;
  logic [VAL_W-1:0] i_guess = '0;
  logic             i_inc_actual = 1'b0;
  logic             i_update_leds = 1'b0;
  logic             i_remain_en = 1'b0;
  logic             o_enter, o_over, o_under, o_equal;
  logic [REM_W-1:0] o_remain;
  logic             o_led_over, o_led_under, o_led_equal;

  guess_datapath #(
    .VAL_W(VAL_W), .REM_W(REM_W), .MAX_GUESSES(4), .DB_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .i_enter_raw(i_enter_raw), .i_guess(i_guess),
    .i_inc_actual(i_inc_actual), .i_update_leds(i_update_leds),
    .i_remain_en(i_remain_en), .o_enter(o_enter), .o_over(o_over),
    .o_under(o_under), .o_equal(o_equal), .o_remain(o_remain),
    .o_led_over(o_led_over), .o_led_under(o_led_under),
    .o_led_equal(o_led_equal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [10:0] mask;
    logic [10:0] val;
  } exp_t;

  exp_t q[$];
  int   ntests = 0;
  int   nfail  = 0;

  wire [10:0] obs = {o_enter, o_over, o_under, o_equal,
                     o_led_over, o_led_under, o_led_equal, o_remain};

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      ntests++;
      if ((obs & e.mask) !== e.val) begin
        nfail++;
        $display("[TB] FAIL %s: got %03h required %03h (mask %03h)",
                 e.name, obs & e.mask, e.val, e.mask);
      end
    end
  end

  function automatic logic [10:0] flg(input logic ov, input logic un, input logic eq);
    flg = {1'b0, ov, un, eq, 7'b0};
  endfunction
  function automatic logic [10:0] led(input logic ov, input logic un, input logic eq);
    led = {4'b0, ov, un, eq, 4'b0};
  endfunction
  function automatic logic [10:0] rem(input int unsigned r);
    rem = {7'b0, 4'(r)};
  endfunction
  function automatic logic [10:0] ent(input logic v);
    ent = {v, 10'b0};
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_out(input string name, input logic [10:0] mask,
                            input logic [10:0] val);
    exp_t e;
    e.name = name;
    e.mask = mask;
    e.val  = val;
    q.push_back(e);
  endtask

`ifdef GUESS_LFSR_EN
  localparam int unsigned A18 = 9;
  localparam logic [10:0] RST_FLG = 11'h100;
  int seq[15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
`else
  localparam int unsigned A18 = 2;
  localparam logic [10:0] RST_FLG = 11'h080;
`endif

  int rem_exp[6] = '{3, 2, 1, 0, 0, 0};

  initial begin
    tick(3);
    reset = 1'b0;
    expect_out("rst_remain", M_REM, rem(4));
    expect_out("rst_leds",   M_LED, led(0, 0, 0));
    expect_out("rst_enter",  M_ENT, ent(0));
    expect_out("rst_flags",  M_FLG, RST_FLG);
    tick(1);

    // 18 steps of actual, wrapping in the binary build
    i_inc_actual = 1'b1;
    tick(18);
    i_inc_actual = 1'b0;
    i_guess = 4'(A18);
    tick(2);
    expect_out("cmp_equal", M_FLG, flg(0, 0, 1));
    i_guess = 4'(A18 + 3);
    tick(2);
    expect_out("cmp_over", M_FLG, flg(1, 0, 0));
    i_guess = 4'(A18 - 1);
    tick(2);
    expect_out("cmp_under", M_FLG, flg(0, 1, 0));

    // LEDs capture and hold
    i_guess = 4'(A18 + 3);
    tick(2);
    i_update_leds = 1'b1;
    tick(1);
    i_update_leds = 1'b0;
    expect_out("led_load_over", M_LED, led(1, 0, 0));
    i_guess = 4'(A18 - 1);
    tick(2);
    expect_out("led_hold_flags", M_FLG, flg(0, 1, 0));
    expect_out("led_hold",       M_LED, led(1, 0, 0));
    tick(3);
    expect_out("led_hold_late", M_LED, led(1, 0, 0));
    i_update_leds = 1'b1;
    tick(1);
    i_update_leds = 1'b0;
    expect_out("led_load_under", M_LED, led(0, 1, 0));

    // remaining counter saturation and reload priority
    i_remain_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      expect_out($sformatf("remain_dec%0d", i), M_REM, rem(rem_exp[i]));
    end
    i_inc_actual = 1'b1;
    tick(1);
    i_inc_actual = 1'b0;
    i_remain_en  = 1'b0;
    expect_out("remain_reload_wins", M_REM, rem(4));

    // short glitch never propagates
    i_enter_raw = 1'b1;
    tick(10);
    i_enter_raw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (i % 5 == 4) expect_out($sformatf("glitch_%0d", i), M_ENT, ent(0));
    end

    // clean rise and fall, 18 clocks each
    i_enter_raw = 1'b1;
    tick(17);
    expect_out("rise_t17", M_ENT, ent(0));
    tick(1);
    expect_out("rise_t18", M_ENT, ent(1));
    tick(2);
    i_enter_raw = 1'b0;
    tick(17);
    expect_out("fall_t17", M_ENT, ent(1));
    tick(1);
    expect_out("fall_t18", M_ENT, ent(0));

`ifdef GUESS_LFSR_EN
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      i_inc_actual = 1'b1;
      tick(1);
      i_inc_actual = 1'b0;
      i_guess = 4'(seq[k % 15]);
      tick(2);
      expect_out($sformatf("lfsr_step%0d", k), M_FLG, flg(0, 0, 1));
    end
`endif

    // asynchronous reset in the middle of a round
    i_remain_en = 1'b1;
    tick(2);
    i_remain_en = 1'b0;
    expect_out("pre_reset_remain", M_REM, rem(2));
    i_inc_actual = 1'b1;
    tick(3);
    i_inc_actual = 1'b0;
    i_remain_en = 1'b1;
    tick(1);
    i_remain_en = 1'b0;
    reset = 1'b1;
    #1;
    expect_out("mid_reset_remain", M_REM, rem(4));
    expect_out("mid_reset_flags",  M_FLG, RST_FLG);
    expect_out("mid_reset_leds",   M_LED, led(0, 0, 0));
    tick(1);
    reset = 1'b0;
    i_guess = 4'd1;
    tick(2);
`ifdef GUESS_LFSR_EN
    expect_out("post_reset_seed", M_FLG, flg(0, 0, 1));
`else
    expect_out("post_reset_zero", M_FLG, flg(1, 0, 0));
`endif

    tick(2);
    if (q.size() != 0) begin
      nfail++;
      $display("[TB] FAIL drain: %0d expectations unchecked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
